// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are captured from EX, converted to magnitudes, iterated DATA_WIDTH times
// (shift-add multiply or restoring divide), then sign-corrected and returned with
// the destination tag. The front of the pipeline is stalled while the op runs.
// Optional build macro MULDIV_EARLY_OUT_EN adds zero-multiply and trivial-divide
// early completion in PREP.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2:0]            FUNC3,
  input  logic [DATA_WIDTH-1:0] OPERAND1,
  input  logic [DATA_WIDTH-1:0] OPERAND2,
  input  logic [4:0]            RD_IN,
  input  logic                  FLUSH,
  output logic                  STALL,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic [4:0]            RD_OUT
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_t;

  // Two's complement negate of a W-bit value when en is set.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
    return en ? (~v + W'(1)) : v;
  endfunction

  // Two's complement negate of a 2W-bit product when en is set.
  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic en);
    return en ? (~v + W2'(1)) : v;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      func3_q, func3_d;
  logic [4:0]      rd_q, rd_d;
  logic            sign1_q, sign1_d;
  logic            sign2_q, sign2_d;
  logic [W-1:0]    op1_q, op1_d;
  logic [W-1:0]    op2_q, op2_d;
  logic            neg_q, neg_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic [4:0]      rdout_q, rdout_d;

  // Signedness of the incoming instruction's operands.
  logic in_s1, in_s2;
  assign in_s1 = (FUNC3 == 3'd1) || (FUNC3 == 3'd2) || (FUNC3 == 3'd4) || (FUNC3 == 3'd6);
  assign in_s2 = (FUNC3 == 3'd1) || (FUNC3 == 3'd4) || (FUNC3 == 3'd6);

  // Decode of the latched operation and operand magnitudes.
  logic         is_div, is_rem, is_mul_lo;
  logic [W-1:0] abs1, abs2;
  assign is_div    = func3_q[2];
  assign is_rem    = func3_q[2] & func3_q[1];
  assign is_mul_lo = (func3_q == 3'd0);
  assign abs1      = neg_w(op1_q, sign1_q);
  assign abs2      = neg_w(op2_q, sign2_q);

  // One iteration. acc holds {partial product, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; op2_q holds the multiplicand or divisor.
  logic [W:0]    mul_sum, div_shift, div_diff;
  logic          div_ge;
  logic [W2-1:0] acc_step;
  assign mul_sum   = {1'b0, acc_q[W2-1:W]} + {1'b0, ({W{acc_q[0]}} & op2_q)};
  assign div_shift = acc_q[W2-1:W-1];
  assign div_diff  = div_shift - {1'b0, op2_q};
  assign div_ge    = ~div_diff[W];
  assign acc_step  = is_div ? {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge}
                            : {mul_sum, acc_q[W-1:1]};

  // Sign-corrected result taken from the accumulator after the final iteration.
  logic [W2-1:0] prod_signed;
  logic [W-1:0]  calc_res;
  assign prod_signed = neg_2w(acc_step, neg_q);
  assign calc_res    = is_div ? (is_rem ? neg_w(acc_step[W2-1:W], neg_q)
                                        : neg_w(acc_step[W-1:0], neg_q))
                              : (is_mul_lo ? prod_signed[W-1:0] : prod_signed[W2-1:W]);

  // Detect operations whose result is known in PREP without iterating.
  logic         fast;
  logic [W-1:0] fast_res;
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (is_div && (op2_q == '0)) begin
      fast     = 1'b1;
      fast_res = is_rem ? op1_q : '1;
    end else if (is_div && !func3_q[0] && (op1_q == MIN_NEG) && (op2_q == '1)) begin
      fast     = 1'b1;
      fast_res = is_rem ? '0 : MIN_NEG;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && ((op1_q == '0) || (op2_q == '0))) begin
      fast     = 1'b1;
      fast_res = '0;
    end else if (is_div && (abs1 < abs2)) begin
      fast     = 1'b1;
      fast_res = is_rem ? op1_q : '0;
    end else if (is_div && (abs2 == W'(1))) begin
      fast     = 1'b1;
      fast_res = is_rem ? '0 : neg_w(abs1, sign1_q ^ sign2_q);
    end
`endif
  end

  // Next-state and datapath update for every state.
  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rdout_d  = rdout_q;
    case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) begin
          func3_d = FUNC3;
          rd_d    = RD_IN;
          sign1_d = OPERAND1[W-1] & in_s1;
          sign2_d = OPERAND2[W-1] & in_s2;
          op1_d   = OPERAND1;
          op2_d   = OPERAND2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_d = is_rem ? sign1_q : (sign1_q ^ sign2_q);
        acc_d = {{W{1'b0}}, (is_div ? abs1 : abs2)};
        op2_d = is_div ? abs2 : abs1;
        cnt_d = '0;
        if (fast) begin
          result_d = fast_res;
          rdout_d  = rd_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        if (cnt_q == LAST_ITER) begin
          result_d = calc_res;
          rdout_d  = rd_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A redirect abandons the operation and leaves the visible result untouched.
    if (FLUSH && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rdout_d  = rdout_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      func3_q  <= '0;
      rd_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rdout_q  <= '0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rdout_q  <= rdout_d;
    end
  end

  assign STALL  = ((state_q == S_IDLE) && START && !FLUSH) ||
                  (state_q == S_PREP) || (state_q == S_CALC);
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;
  assign RD_OUT = rdout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed vector table, multi-cycle corner
// sequences (flush, flush+start, mid-op reset, START held while busy) and
// randomized operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_in;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .START(start), .FUNC3(func3),
    .OPERAND1(op1), .OPERAND2(op2), .RD_IN(rd_in), .FLUSH(flush),
    .STALL(stall), .BUSY(busy), .DONE(done), .RESULT(result), .RD_OUT(rd_out)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat_def;
    int          lat_early;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic on the RISC-V M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Expected START-to-DONE distance in cycles.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    longint ma, mb;
    bit     s1, s2;
`endif
    if (f3[2] && b == 32'd0) return 2;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    s1 = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    s2 = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    ma = (s1 && a[31]) ? -longint'($signed(a)) : longint'({32'b0, a});
    mb = (s2 && b[31]) ? -longint'($signed(b)) : longint'({32'b0, b});
    if (!f3[2]) return (a == 32'd0 || b == 32'd0) ? 2 : 34;
    if (ma < mb || mb == 1) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op in the current cycle (called #1 after a rising edge) and follows it
  // to DONE; returns #1 after the edge that leaves DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold,
                        output bit seen, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output bit stall_ok, output bit busy_ok,
                        output bit stall_done);
    start = 1'b1; func3 = f3; op1 = a; op2 = b; rd_in = rd;
    @(negedge clk);
    stall_ok = stall;
    busy_ok  = !busy;
    @(posedge clk); #1;
    if (hold) begin
      func3 = 3'($urandom_range(0, 7)); op1 = $urandom; op2 = $urandom;
      rd_in = 5'($urandom_range(0, 31));
    end else begin
      start = 1'b0;
    end
    lat = 1; seen = 1'b0; res = '0; rdo = '0; stall_done = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; res = result; rdo = rd_out; stall_done = stall;
        busy_ok = busy_ok & busy;
        break;
      end
      stall_ok = stall_ok & stall;
      busy_ok  = busy_ok & busy;
      @(posedge clk); #1;
      lat++;
      if (hold && lat >= 33) start = 1'b0;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Counts DONE pulses over a window of cycles.
  task automatic watch_no_done(input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk(name, 64'(pulses), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          seen, s_ok, b_ok, s_done;
    int          lat, exp_lat;
    logic [31:0] res, prev;
    logic [4:0]  rdo;

    vecs[0]  = '{3'd0, 32'd7,         32'd6,         5'd3,  32'h0000_002A, 34, 34};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 34, 34};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 34, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 34, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 34, 34};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'h7FFF_FFFC, 34, 34};
    vecs[7]  = '{3'd4, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF, 2,  2};
    vecs[8]  = '{3'd7, 32'd100,       32'd0,         5'd11, 32'd100,       2,  2};
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2,  2};
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 2,  2};
    vecs[11] = '{3'd0, 32'd0,         32'd5,         5'd14, 32'h0000_0000, 34, 2};
    vecs[12] = '{3'd5, 32'd3,         32'd10,        5'd15, 32'h0000_0000, 34, 2};
    vecs[13] = '{3'd4, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 5'd31, 32'h0000_0009, 34, 2};

    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",   64'(busy),   64'd0);
    chk("reset_done",   64'(done),   64'd0);
    chk("reset_stall",  64'(stall),  64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
      exp_lat = vecs[i].lat_early;
`else
      exp_lat = vecs[i].lat_def;
`endif
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0,
             seen, lat, res, rdo, s_ok, b_ok, s_done);
      chk($sformatf("vec%0d_done_seen", i), 64'(seen), 64'd1);
      chk($sformatf("vec%0d_latency", i),   64'(lat),  64'(exp_lat));
      chk($sformatf("vec%0d_result", i),    64'(res),  64'(vecs[i].exp));
      chk($sformatf("vec%0d_rd_out", i),    64'(rdo),  64'(vecs[i].rd));
      chk($sformatf("vec%0d_stall_run", i), 64'(s_ok), 64'd1);
      chk($sformatf("vec%0d_busy", i),      64'(b_ok), 64'd1);
      chk($sformatf("vec%0d_stall_done", i), 64'(s_done), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_after", i), 64'({done, busy}), 64'd0);
      chk($sformatf("vec%0d_result_hold", i), 64'(result), 64'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // FLUSH in the middle of a divide.
    prev = result;
    start = 1'b1; func3 = 3'd4; op1 = 32'd1000; op2 = 32'd7; rd_in = 5'd20;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stall",  64'(stall),  64'd0);
    chk("flush_busy",   64'(busy),   64'd0);
    chk("flush_done",   64'(done),   64'd0);
    chk("flush_result", 64'(result), 64'(prev));
    @(posedge clk); #1;
    watch_no_done("flush_no_done");

    // FLUSH together with START in IDLE.
    start = 1'b1; flush = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd3; rd_in = 5'd21;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    watch_no_done("flush_start_no_done");
    chk("flush_start_result", 64'(result), 64'(prev));

    // START held high with other operands while busy is ignored.
    run_op(3'd5, 32'd1000, 32'd7, 5'd17, 1'b1, seen, lat, res, rdo, s_ok, b_ok, s_done);
    chk("hold_done_seen", 64'(seen), 64'd1);
    chk("hold_latency",   64'(lat),  64'd34);
    chk("hold_result",    64'(res),  64'd142);
    chk("hold_rd_out",    64'(rdo),  64'd17);

    // Reset in the middle of a multiply.
    start = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd3; rd_in = 5'd22;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy",   64'(busy),   64'd0);
    chk("midrst_done",   64'(done),   64'd0);
    chk("midrst_stall",  64'(stall),  64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_rd_out", 64'(rd_out), 64'd0);
    @(posedge clk); #1;
    watch_no_done("midrst_no_done");

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      logic [4:0]  rrd;
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      rrd = 5'($urandom_range(0, 31));
      run_op(rf3, ra, rb, rrd, 1'b0, seen, lat, res, rdo, s_ok, b_ok, s_done);
      chk($sformatf("rand%0d_f%0d_done_seen", n, rf3), 64'(seen), 64'd1);
      chk($sformatf("rand%0d_f%0d_latency a=%h b=%h", n, rf3, ra, rb),
          64'(lat), 64'(ref_latency(rf3, ra, rb)));
      chk($sformatf("rand%0d_f%0d_result a=%h b=%h", n, rf3, ra, rb),
          64'(res), 64'(ref_result(rf3, ra, rb)));
      chk($sformatf("rand%0d_rd_out", n), 64'(rdo), 64'(rrd));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and datapath for the RV32M operations issued from the EX stage. It captures the operands, runs 32 shift-add or shift-subtract iterations, and returns the result with the destination register tag. While an operation is in flight it stalls the front of the pipeline. The ALU in EX keeps all single-cycle RV32I work; this block owns every FUNC3 of the M extension.

Parameters:
DATA_WIDTH, 32, operand and result width; the iteration count equals DATA_WIDTH.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  M-extension instruction valid in EX
FUNC3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
OPERAND1  input  32  rs1 value after forwarding
OPERAND2  input  32  rs2 value after forwarding
RD_IN  input  5  destination register
FLUSH  input  1  kill the in-flight operation (branch or jump redirect)
STALL  output  1  freeze PC, IF/ID and ID/EX
BUSY  output  1  operation in flight
DONE  output  1  one-cycle pulse: RESULT and RD_OUT valid
RESULT  output  32  final value
RD_OUT  output  5  latched RD_IN

Behaviour:
- Interface: one clock CLK. RST is synchronous and active-high.
- Reset values: state IDLE, BUSY 0, DONE 0, STALL 0, RESULT 0, RD_OUT 0. All internal registers are cleared.
- States:
  - IDLE: START=1 and FLUSH=0 latches FUNC3, RD_IN, the operand signs and both operands, then moves to PREP.
  - PREP: takes the absolute value of each operand as the FUNC3 requires:
    - Signed: MULH, DIV, REM.
    - rs1 signed only: MULHSU.
    - Unsigned: MUL, MULHU, DIVU, REMU.
    - Sets the result-negate flag.
    - Clears the 64-bit accumulator or the remainder and the iteration counter.
    - Goes to DONE on a fast path, otherwise to CALC.
  - CALC: one iteration per cycle; the counter runs 0..31 and moves to DONE when it equals 31.
    - Multiply: add the multiplicand when the multiplier LSB is 1, then shift right.
    - Divide: shift the remainder left, subtract the divisor when the result is non-negative, shift the quotient bit in.
  - DONE: DONE=1 and RESULT is registered, then returns to IDLE the next cycle.
- Result selection:
  - MUL returns the low 32 bits. MULH, MULHSU and MULHU return the high 32 bits.
  - DIV and DIVU return the quotient. REM and REMU return the remainder.
  - Signed results are negated in two's complement. The quotient sign is sign1 XOR sign2; the remainder takes the dividend's sign.
- Latency: START sampled at cycle t gives PREP at t+1, CALC at t+2..t+33 and DONE at t+34. A fast path gives DONE at t+2.
- Mandatory fast paths, with no CALC:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- STALL = (IDLE and START and not FLUSH) or PREP or CALC. STALL is 0 in the DONE cycle so the pipeline advances and captures RESULT.
- BUSY = 1 in PREP, CALC and DONE.
- RESULT holds its value after DONE until the next DONE.
- START while not in IDLE is ignored. The pipeline holds the instruction through STALL.
- FLUSH in any non-IDLE state returns the block to IDLE on the next edge. There is no DONE pulse and RESULT is unchanged.
- FLUSH together with START in IDLE: FLUSH wins and the operation is not accepted.
- RST mid-operation forces the reset values on the next edge.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: PREP also takes the fast path to DONE at t+2 in three cases:
  - Multiply with either operand equal to 0: result 0.
  - Divide with |dividend| < |divisor|, divisor not zero: quotient 0, remainder = original dividend.
  - Divide with a divisor magnitude of 1: quotient is the correctly signed dividend, remainder 0.
- Undefined: only divide-by-zero and signed overflow take the fast path; every other operation has DONE at t+34.

Test Plan:
- MUL 7 × 6 at t → STALL 1 for t..t+33, DONE at t+34, RESULT 0x0000002A, RD_OUT = RD_IN.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 % 2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. All with DONE at t+34.
- DIV 100 / 0 → DONE at t+2, 0xFFFFFFFF. REMU 100 % 0 → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at t+2. REM of the same operands → 0.
- FLUSH at t+10 during a DIV → IDLE at t+11, STALL 0, no DONE, RESULT unchanged. FLUSH with START in IDLE → nothing accepted. RST at t+5 → all outputs 0 on the next edge.
- MULDIV_EARLY_OUT_EN defined:
  - MUL 0 × 5 → DONE at t+2, RESULT 0.
  - DIVU 3 / 10 → DONE at t+2, RESULT 0.
  - DIV −9 / −1 → DONE at t+2, RESULT 9.
  - Undefined: the same stimuli give DONE at t+34.
